dram_burst_ctrl: RTL and testbench

- Memory-side responder for the instruction cache's refill port. Sits directly downstream of the icache.
- Samples the cache's level request `dram_req` and its block address. After a fixed access latency it streams one cache line of BLOCK_SIZE 32-bit words, one per cycle, each qualified by `dram_val`.
- Backed by a synchronous on-chip word RAM, preloadable through a loader write port.

---
 rtl/mem_pkg.sv | 19 +
 rtl/sp_wordram.sv | 36 +++
 rtl/dram_burst_ctrl.sv | 145 ++++++++++++++
 tb/tb_dram_burst_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_pkg: shared types and constants for the icache refill responder |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DRAIN = 2'd3
    } burst_state_t;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int WORD_BYTES       = 4;

endpackage
`default_nettype wire

// File: rtl/sp_wordram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sp_wordram: synchronous-read word RAM, independent write, read-first |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module sp_wordram #(
    parameter int    AW        = 12,
    parameter int    DW        = 32,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Read and write share the edge; the read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dram_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dram_burst_ctrl: fixed-latency line-burst responder for icache refill|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module dram_burst_ctrl
    import mem_pkg::*;
#(
    parameter int    BLOCK_SIZE = 8,
    parameter int    LATENCY    = 4,
    parameter int    MEM_AW     = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dram_req,
    input  logic [31:0]       dram_req_addr,
    output logic [31:0]       dram_data,
    output logic              dram_val,
    output logic              busy,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam int                BEAT_W    = LINE_OFFSET_BITS - $clog2(WORD_BYTES);
    localparam int                LINE_W    = MEM_AW - BEAT_W;
    localparam int                LINE_LSB  = LINE_OFFSET_BITS;
    localparam logic [3:0]        LAT_LAST  = 4'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_SIZE - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    burst_state_t      state_q;
    logic [LINE_W-1:0] line_q;
    logic [3:0]        lat_cnt_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic              val_q;
    logic [31:0]       data_q;
    logic              busy_q;

    logic              w_ram_re;
    logic [BEAT_W-1:0] w_rd_beat;
    logic [MEM_AW-1:0] w_ram_raddr;
    logic [31:0]       w_ram_rdata;
    logic              w_unused_addr;

    assign w_unused_addr = ^{dram_req_addr[31:LINE_LSB+LINE_W], dram_req_addr[LINE_LSB-1:0]};

    // The RAM captures beat i+1 on the same edge that loads beat i into the
    // output register, so beats stream back-to-back with no bubble.
    always_comb begin
        w_ram_re  = 1'b0;
        w_rd_beat = '0;
        if (dram_req) begin
            if (state_q == WAIT && lat_cnt_q == LAT_LAST) begin
                w_ram_re = 1'b1;
            end else if (state_q == BURST && beat_cnt_q != BEAT_LAST) begin
                w_ram_re  = 1'b1;
                w_rd_beat = beat_cnt_q + BEAT_ONE;
            end
        end
    end

    assign w_ram_raddr = {line_q, w_rd_beat};

    sp_wordram #(
        .AW        (MEM_AW),
        .DW        (32),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .we_i    (ld_we),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .re_i    (w_ram_re),
        .raddr_i (w_ram_raddr),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            line_q     <= '0;
            lat_cnt_q  <= '0;
            beat_cnt_q <= '0;
            val_q      <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            val_q  <= 1'b0;
            data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (dram_req) begin
                        line_q    <= dram_req_addr[LINE_LSB +: LINE_W];
                        lat_cnt_q <= '0;
                        state_q   <= WAIT;
                        busy_q    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!dram_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (lat_cnt_q == LAT_LAST) begin
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 4'd1;
                    end
                end
                BURST: begin
                    if (!dram_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        val_q      <= 1'b1;
                        data_q     <= w_ram_rdata;
                        beat_cnt_q <= beat_cnt_q + BEAT_ONE;
                        if (beat_cnt_q == BEAT_LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // A request still held after the last beat belongs to the finished line.
                    if (!dram_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dram_data = data_q;
    assign dram_val  = val_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dram_burst_ctrl: self-checking bench with a word-array memory model|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_dram_burst_ctrl;

    localparam int BS  = 8;
    localparam int LAT = 4;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          dram_req;
    logic [31:0]   dram_req_addr;
    logic [31:0]   dram_data;
    logic          dram_val;
    logic          busy;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [0:(1<<AW)-1];
    logic [31:0] cap_q [$];
    int          cap_first;
    int          cap_last;
    logic        cap_busy1;
    bit          cap_timeout;

    dram_burst_ctrl #(
        .BLOCK_SIZE (BS),
        .LATENCY    (LAT),
        .MEM_AW     (AW),
        .INIT_FILE  ("")
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dram_req      (dram_req),
        .dram_req_addr (dram_req_addr),
        .dram_data     (dram_data),
        .dram_val      (dram_val),
        .busy          (busy),
        .ld_we         (ld_we),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word index of beat i: the line number modulo the RAM's line count, times line size.
    function automatic int exp_word(input logic [31:0] addr, input int i);
        int line;
        line = int'((addr / 32'd32) % 32'((1 << AW) / BS));
        return line * BS + i;
    endfunction

    // Acts as the cache: holds the request until BS beats plus 2 cycles, then drops it for one cycle.
    task automatic run_burst(input logic [31:0] addr, input bit scramble, input int ld_t,
                             input logic [AW-1:0] la, input logic [31:0] ld);
        int t;
        int post;
        cap_q.delete();
        cap_first = -1;
        cap_last = -1;
        cap_timeout = 0;
        cap_busy1 = 1'b0;
        dram_req = 1'b1;
        dram_req_addr = addr;
        t = 0;
        post = -1;
        while (post < 2 && !cap_timeout) begin
            if (t == ld_t) begin
                ld_we = 1'b1;
                ld_addr = la;
                ld_data = ld;
            end
            tick();
            t++;
            ld_we = 1'b0;
            if (scramble) dram_req_addr = $urandom();
            if (t == 1) cap_busy1 = busy;
            if (dram_val === 1'b1) begin
                cap_q.push_back(dram_data);
                if (cap_first < 0) cap_first = t;
                cap_last = t;
            end
            if (post >= 0) post++;
            else if (cap_q.size() >= BS) post = 0;
            if (t >= 60) cap_timeout = 1;
        end
        dram_req = 1'b0;
        tick();
        if (dram_val === 1'b1) cap_q.push_back(dram_data);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dram_req = 1'b0;
        dram_req_addr = '0;
        ld_we = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        tick();
        tick();
        checks++; if (dram_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b required 0", dram_val); end
        checks++; if (dram_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", dram_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic preload();
        for (int w = 0; w < (1 << AW); w++) begin
            ld_we = 1'b1;
            ld_addr = AW'(w);
            ld_data = 32'h1000_0000 + 32'(w);
            model_mem[w] = 32'h1000_0000 + 32'(w);
            tick();
        end
        ld_we = 1'b0;
    endtask

    task automatic test_basic();
        run_burst(32'h0000_0040, 1'b0, -1, '0, '0);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL basic_count: got %0d required %0d", cap_q.size(), BS); end
        checks++; if (cap_first != LAT + 2) begin errors++; $display("FAIL basic_first: got %0d required %0d", cap_first, LAT + 2); end
        checks++; if (cap_last != LAT + BS + 1) begin errors++; $display("FAIL basic_last: got %0d required %0d", cap_last, LAT + BS + 1); end
        checks++; if (cap_busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy_hi: got %b required 1", cap_busy1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_lo: got %b required 0", busy); end
        for (int i = 0; i < BS && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== 32'h1000_0010 + 32'(i)) begin
                errors++; $display("FAIL basic_beat%0d: got %h required %h", i, cap_q[i], 32'h1000_0010 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        run_burst(32'h0000_0040, 1'b0, -1, '0, '0);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL b2b_count1: got %0d required %0d", cap_q.size(), BS); end
        run_burst(32'h0000_0060, 1'b0, -1, '0, '0);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL b2b_count2: got %0d required %0d", cap_q.size(), BS); end
        checks++; if (cap_first != LAT + 2) begin errors++; $display("FAIL b2b_first: got %0d required %0d", cap_first, LAT + 2); end
        for (int i = 0; i < BS && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== model_mem[exp_word(32'h60, i)]) begin
                errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, cap_q[i], model_mem[exp_word(32'h60, i)]);
            end
        end
    endtask

    task automatic test_alias();
        run_burst(32'h0000_405C, 1'b1, -1, '0, '0);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL alias_count: got %0d required %0d", cap_q.size(), BS); end
        for (int i = 0; i < BS && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== 32'h1000_0010 + 32'(i)) begin
                errors++; $display("FAIL alias_beat%0d: got %h required %h", i, cap_q[i], 32'h1000_0010 + 32'(i));
            end
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int t = 0;
        dram_req = 1'b1;
        dram_req_addr = 32'h0000_0000;
        while (n < 2 && t < 40) begin
            tick();
            t++;
            if (dram_val === 1'b1) begin
                checks++;
                if (dram_data !== model_mem[exp_word(32'h0, n)]) begin
                    errors++; $display("FAIL abort_beat%0d: got %h required %h", n, dram_data, model_mem[exp_word(32'h0, n)]);
                end
                n++;
            end
        end
        checks++; if (n != 2) begin errors++; $display("FAIL abort_start: got %0d beats required 2", n); end
        dram_req = 1'b0;
        tick();
        checks++; if (dram_val !== 1'b0) begin errors++; $display("FAIL abort_val: got %b required 0", dram_val); end
        checks++; if (dram_data !== 32'h0) begin errors++; $display("FAIL abort_data: got %h required 0", dram_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        tick();
        checks++; if (dram_val !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %b required 0", dram_val); end
        run_burst(32'h0000_0000, 1'b0, -1, '0, '0);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL abort_rerun_count: got %0d required %0d", cap_q.size(), BS); end
        for (int i = 0; i < BS && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== model_mem[exp_word(32'h0, i)]) begin
                errors++; $display("FAIL abort_rerun%0d: got %h required %h", i, cap_q[i], model_mem[exp_word(32'h0, i)]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int t = 0;
        dram_req = 1'b1;
        dram_req_addr = 32'h0000_0040;
        while (n < 4 && t < 40) begin
            tick();
            t++;
            if (dram_val === 1'b1) n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rstmid_start: got %0d beats required 4", n); end
        reset = 1'b1;
        dram_req = 1'b0;
        tick();
        checks++; if (dram_val !== 1'b0) begin errors++; $display("FAIL rstmid_val: got %b required 0", dram_val); end
        checks++; if (dram_data !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h required 0", dram_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        reset = 1'b0;
        tick();
        checks++; if (dram_val !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got %b required 0", dram_val); end
        run_burst(32'h0000_0040, 1'b0, -1, '0, '0);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL rstmid_count: got %0d required %0d", cap_q.size(), BS); end
        for (int i = 0; i < BS && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== model_mem[exp_word(32'h40, i)]) begin
                errors++; $display("FAIL rstmid_beat%0d: got %h required %h", i, cap_q[i], model_mem[exp_word(32'h40, i)]);
            end
        end
    endtask

    // Beat 2's word is read on the edge that registers beat 1, i.e. the 7th edge after the request.
    task automatic test_collision();
        run_burst(32'h0000_0040, 1'b0, LAT + 2, AW'(12'h012), 32'hDEAD_BEEF);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL coll_count: got %0d required %0d", cap_q.size(), BS); end
        for (int i = 0; i < BS && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== model_mem[exp_word(32'h40, i)]) begin
                errors++; $display("FAIL coll_old%0d: got %h required %h", i, cap_q[i], model_mem[exp_word(32'h40, i)]);
            end
        end
        model_mem[12'h012] = 32'hDEAD_BEEF;
        run_burst(32'h0000_0040, 1'b0, -1, '0, '0);
        checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL coll_count2: got %0d required %0d", cap_q.size(), BS); end
        for (int i = 0; i < BS && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== model_mem[exp_word(32'h40, i)]) begin
                errors++; $display("FAIL coll_new%0d: got %h required %h", i, cap_q[i], model_mem[exp_word(32'h40, i)]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          w;
        logic [31:0] d;
        int          gap;
        for (int n = 0; n < 10; n++) begin
            addr = $urandom();
            for (int k = 0; k < 3; k++) begin
                w = (k == 0) ? exp_word(addr, int'($urandom_range(0, BS - 1))) : int'($urandom_range(0, (1 << AW) - 1));
                d = $urandom();
                ld_we = 1'b1;
                ld_addr = AW'(w);
                ld_data = d;
                model_mem[w] = d;
                tick();
            end
            ld_we = 1'b0;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            run_burst(addr, 1'($urandom_range(0, 1)), -1, '0, '0);
            checks++; if (cap_q.size() != BS) begin errors++; $display("FAIL rand%0d_count: got %0d required %0d", n, cap_q.size(), BS); end
            checks++; if (cap_first != LAT + 2) begin errors++; $display("FAIL rand%0d_first: got %0d required %0d", n, cap_first, LAT + 2); end
            for (int i = 0; i < BS && i < cap_q.size(); i++) begin
                checks++;
                if (cap_q[i] !== model_mem[exp_word(addr, i)]) begin
                    errors++; $display("FAIL rand%0d_beat%0d: got %h required %h", n, i, cap_q[i], model_mem[exp_word(addr, i)]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_back_to_back();
        test_alias();
        test_abort();
        test_reset_mid();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
